// File: rtl/rv_slice_sequencer_pkg.sv
// Shared encoder definitions: slice geometry,
// sequencer state encoding and the chi row function.
package rv_slice_sequencer_pkg;

  localparam int SLICE_W = 25;
  localparam int ROW_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [ROW_W-1:0] chi_row(
    input logic [ROW_W-1:0] a
  );
    logic [ROW_W-1:0] r;
    r = '0;
    for (int x = 0; x < ROW_W; x++) begin
      r[x] = a[x] ^ (~a[(x+1)%ROW_W] & a[(x+2)%ROW_W]);
    end
    return r;
  endfunction

endpackage

// File: rtl/rv_slice_sequencer_chi.sv
// Combinational chi on one 5-bit row of a slice.
// Used five times per slice by the sequencer.
module rv_chi_row
  import rv_slice_sequencer_pkg::*;
(
  input  logic [ROW_W-1:0] i_a,
  output logic [ROW_W-1:0] o_y
);

  assign o_y = chi_row(i_a);

endmodule

// File: rtl/rv_slice_sequencer_reg.sv
// Loadable register with asynchronous active-low clear.
// Holds its value unless i_ld is high.
module rv_ld_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/rv_slice_sequencer.sv
// Chi stage sequencer: read slice, latch, write
// chi(slice) downstream, for every slice in order.
module rv_slice_sequencer
  import rv_slice_sequencer_pkg::*;
#(
  parameter int SLICES = 64,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [SLICE_W-1:0] rd_data,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [SLICE_W-1:0] wr_data,
  output logic               busy,
  output logic               done
);

  state_t r_state;
  state_t w_next;

  logic              w_cnt_ld;
  logic [ADDR_W-1:0] w_cnt_d;
  logic [ADDR_W-1:0] w_cnt;
  logic              w_slice_ld;
  logic [SLICE_W-1:0] w_slice;
  logic [SLICE_W-1:0] w_chi;
  logic              w_last;

  assign w_last = (w_cnt == ADDR_W'(SLICES-1));

  rv_ld_reg #(.W(ADDR_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_ld  (w_cnt_ld),
    .i_d   (w_cnt_d),
    .o_q   (w_cnt)
  );

  rv_ld_reg #(.W(SLICE_W)) u_slice (
    .clk   (clk),
    .rst_n (rst),
    .i_ld  (w_slice_ld),
    .i_d   (rd_data),
    .o_q   (w_slice)
  );

  for (genvar y = 0; y < 5; y++) begin : g_row
    rv_chi_row u_row (
      .i_a (w_slice[ROW_W*y +: ROW_W]),
      .o_y (w_chi[ROW_W*y +: ROW_W])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_ld   = 1'b0;
    w_cnt_d    = '0;
    w_slice_ld = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next   = S_READ;
          w_cnt_ld = 1'b1;
        end
      end
      S_READ: begin
        rd_en   = 1'b1;
        rd_addr = w_cnt;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        w_slice_ld = 1'b1;
        w_next     = S_WRITE;
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = w_cnt;
        wr_data = w_chi;
        if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next   = S_READ;
          w_cnt_ld = 1'b1;
          w_cnt_d  = w_cnt + ADDR_W'(1);
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rv_slice_sequencer.sv
// Directed bench for rv_slice_sequencer with
// behavioural source/destination slice memories.
module tb_rv_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [24:0] rd_data = '0;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [24:0] wr_data;
  logic        busy;
  logic        done;

  rv_slice_sequencer #(.SLICES(64), .ADDR_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  logic [24:0] src [64];
  logic [24:0] dst [64];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int wr_cnt, order_bad, overlap, done_cnt;
  int done_at, busy_gap, mark;
  int strobe_bad, busy_bad;
  bit watch = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];

  always @(negedge clk) begin
    if (rd_en && wr_en) overlap++;
    if (wr_en) begin
      if (wr_addr !== 6'(wr_cnt)) order_bad++;
      dst[wr_addr] = wr_data;
      wr_cnt++;
    end
    if (done) done_cnt++;
    if (watch && (rd_en || wr_en)) strobe_bad++;
    if (watch && busy) busy_bad++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [24:0] v);
    for (int i = 0; i < 64; i++) begin
      src[i] = v;
      dst[i] = 25'h0155555;
    end
  endtask

  task automatic run_pass(input bit glitch);
    int rel;
    wr_cnt = 0; order_bad = 0; overlap = 0;
    done_cnt = 0; done_at = -1; busy_gap = 0;
    start = 1'b1;
    mark = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      rel = cyc - mark;
      if (done && done_at < 0) done_at = rel;
      if (rel >= 1 && rel <= 193 && !busy) busy_gap++;
      if (glitch) start = (rel == 10 || rel == 150);
      if (rel >= 196) break;
      tick();
    end
    start = 1'b0;
  endtask

  function automatic int count_ne(input logic [24:0] v);
    int n = 0;
    for (int i = 0; i < 64; i++)
      if (dst[i] !== v) n++;
    return n;
  endfunction

  initial begin
    int bad;
    for (int i = 0; i < 64; i++) src[i] = '0;
    tick();
    tick();
    chk("reset_outs",
        64'({rd_en, rd_addr, wr_en, wr_addr,
             wr_data, busy, done}), 64'd0);
    rst = 1'b1;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // all-zero source, with start pulses while busy
    fill(25'h0);
    run_pass(1'b1);
    chk("z_done_cyc", 64'(done_at), 64'd193);
    chk("z_done_cnt", 64'(done_cnt), 64'd1);
    chk("z_writes", 64'(wr_cnt), 64'd64);
    chk("z_order", 64'(order_bad), 64'd0);
    chk("z_overlap", 64'(overlap), 64'd0);
    chk("z_busy_gap", 64'(busy_gap), 64'd0);
    chk("z_idle_after", 64'(busy), 64'd0);
    chk("z_data", 64'(count_ne(25'h0)), 64'd0);

    // all-ones is a chi fixed point
    fill(25'h1FFFFFF);
    run_pass(1'b0);
    chk("o_done_cyc", 64'(done_at), 64'd193);
    chk("o_writes", 64'(wr_cnt), 64'd64);
    chk("o_data", 64'(count_ne(25'h1FFFFFF)), 64'd0);

    // single bits: row0 x=1 and row4 x=4 (wraps)
    fill(25'h0);
    src[5]  = 25'h0000002;
    src[63] = 25'h1000000;
    run_pass(1'b0);
    chk("s_slice5", 64'(dst[5]), 64'h12);
    chk("s_slice63", 64'(dst[63]), 64'h1400000);
    bad = 0;
    for (int i = 0; i < 63; i++)
      if (i != 5 && dst[i] !== 25'h0) bad++;
    chk("s_others", 64'(bad), 64'd0);
    chk("s_writes", 64'(wr_cnt), 64'd64);

    // start held high: new pass right after IDLE
    fill(25'h0);
    wr_cnt = 0; order_bad = 0; done_cnt = 0;
    start = 1'b1;
    mark = cyc;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (cyc - mark == 193) chk("h_done", 64'(done), 64'd1);
      if (cyc - mark == 194) chk("h_idle", 64'(busy), 64'd0);
      if (cyc - mark >= 195) break;
    end
    chk("h_restart",
        64'({rd_en, rd_addr}), 64'({1'b1, 6'd0}));
    start = 1'b0;
    for (int k = 0; k < 300 && !done; k++) tick();
    chk("h_second_done", 64'(done), 64'd1);
    tick();

    // reset in the middle of a pass
    start = 1'b1;
    mark = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100 && (cyc - mark) < 40; k++) tick();
    rst = 1'b0;
    strobe_bad = 0;
    busy_bad = 0;
    watch = 1'b1;
    tick();
    chk("r_outs",
        64'({rd_en, rd_addr, wr_en, wr_addr,
             wr_data, busy, done}), 64'd0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    watch = 1'b0;
    chk("r_strobes", 64'(strobe_bad), 64'd0);
    chk("r_busy", 64'(busy_bad), 64'd0);
    fill(25'h1FFFFFF);
    run_pass(1'b0);
    chk("r_done_cyc", 64'(done_at), 64'd193);
    chk("r_writes", 64'(wr_cnt), 64'd64);
    chk("r_order", 64'(order_bad), 64'd0);
    chk("r_data", 64'(count_ne(25'h1FFFFFF)), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
